// File: rtl/tetris_pkg.sv
// tetris_pkg: block code constants, widths and helpers shared by the queue and draw stages
package tetris_pkg;
  localparam int BLOCK_W = 5;
  localparam logic [BLOCK_W-1:0] NO_BLOCK = 5'b00000;
  localparam logic [BLOCK_W-1:0] I_BLOCK = 5'b10000;
  localparam logic [BLOCK_W-1:0] O_BLOCK = 5'b10001;
  localparam logic [BLOCK_W-1:0] T_BLOCK = 5'b10010;
  localparam logic [BLOCK_W-1:0] S_BLOCK = 5'b10011;
  localparam logic [BLOCK_W-1:0] Z_BLOCK = 5'b10100;
  localparam logic [BLOCK_W-1:0] J_BLOCK = 5'b10101;
  localparam logic [BLOCK_W-1:0] L_BLOCK = 5'b10110;
  typedef enum logic {NBQ_FILL, NBQ_FULL} nbq_state_e;
  function automatic logic is_legal_code(input logic [BLOCK_W-1:0] c);
    return c[4:3] == 2'b10 && c[2:0] != 3'b111;
  endfunction
endpackage

// File: rtl/nbq_candidate_filter.sv
// nbq_candidate_filter: turns random bits into a block candidate; NBQ_NO_REPEAT_EN adds anti-repeat with forced accept
module nbq_candidate_filter
  import tetris_pkg::*;
#(
  parameter int MAX_RETRY = 7
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [2:0]         random_i,
  input  logic               push_i,
  output logic [BLOCK_W-1:0] cand_o,
  output logic               cand_ok_o
);
  assign cand_o = {2'b10, random_i};
`ifdef NBQ_NO_REPEAT_EN
  logic [BLOCK_W-1:0] last_q;
  logic [7:0] retry_q;
  logic hit, force_ok;
  // repeat of the last pushed code is refused until the retry budget is spent
  always_comb begin
    hit = cand_o == last_q;
    force_ok = retry_q >= 8'(MAX_RETRY);
    cand_ok_o = is_legal_code(cand_o) && (!hit || force_ok);
  end
  // remember what was pushed and count consecutive repeat rejections
  always_ff @(posedge pclk) begin
    if (rst) begin
      last_q <= NO_BLOCK;
      retry_q <= '0;
    end else if (push_i) begin
      last_q <= cand_o;
      retry_q <= '0;
    end else if (is_legal_code(cand_o) && hit && !force_ok) begin
      retry_q <= retry_q + 8'd1;
    end
  end
`else
  logic unused_ok;
  assign cand_ok_o = is_legal_code(cand_o);
  assign unused_ok = &{1'b0, pclk, rst, push_i, MAX_RETRY != 0};
`endif
endmodule

// File: rtl/next_block_queue.sv
// next_block_queue: filtered block FIFO with req/ack issue and vblank-synchronous preview (option NBQ_NO_REPEAT_EN)
module next_block_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int MAX_RETRY = 7
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [4:0]         random,
  input  logic               vblnk_in,
  input  logic               take_req,
  output logic               take_ack,
  output logic [BLOCK_W-1:0] cur_block,
  output logic [BLOCK_W-1:0] buf_block,
  output logic [3:0]         q_count
);
  nbq_state_e state_q, state_d;
  logic [BLOCK_W-1:0] q_q [DEPTH];
  logic [BLOCK_W-1:0] q_d [DEPTH];
  logic [3:0] count_q, count_d, widx;
  logic ack_q, ack_d, vblnk_q, pop, push, cand_ok, unused_ok;
  logic [BLOCK_W-1:0] cur_q, cur_d, buf_q, buf_d, cand;
  assign unused_ok = &{1'b0, random[4:3]};
  nbq_candidate_filter #(.MAX_RETRY(MAX_RETRY)) u_filter (
    .pclk      (pclk),
    .rst       (rst),
    .random_i  (random[2:0]),
    .push_i    (push),
    .cand_o    (cand),
    .cand_ok_o (cand_ok)
  );
  // fill-state register
  always_ff @(posedge pclk) begin
    state_q <= rst ? NBQ_FILL : state_d;
  end
  // push/pop decision, queue shift with tail write, handshake and preview next-state
  always_comb begin
    pop = take_req && count_q != 4'd0 && !ack_q;
    push = cand_ok && (state_q == NBQ_FILL || pop);
    count_d = count_q + 4'(push) - 4'(pop);
    state_d = count_d == 4'(DEPTH) ? NBQ_FULL : NBQ_FILL;
    widx = pop ? count_q - 4'd1 : count_q;
    for (int i = 0; i < DEPTH; i++) begin
      q_d[i] = pop ? (i == DEPTH - 1 ? NO_BLOCK : q_q[(i + 1) % DEPTH]) : q_q[i];
      if (push && widx == 4'(i)) q_d[i] = cand;
    end
    ack_d = pop;
    cur_d = pop ? q_q[0] : cur_q;
    buf_d = vblnk_in && !vblnk_q && count_q != 4'd0 ? q_q[0] : buf_q;
  end
  // registered datapath so every output comes straight from a flop
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= NO_BLOCK;
      count_q <= '0;
      ack_q <= 1'b0;
      cur_q <= NO_BLOCK;
      buf_q <= NO_BLOCK;
      vblnk_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
      count_q <= count_d;
      ack_q <= ack_d;
      cur_q <= cur_d;
      buf_q <= buf_d;
      vblnk_q <= vblnk_in;
    end
  end
  assign take_ack = ack_q;
  assign cur_block = cur_q;
  assign buf_block = buf_q;
  assign q_count = count_q;
endmodule

// File: tb/tb_next_block_queue.sv
// tb_next_block_queue: directed stimulus with an ack scoreboard checked by an independent monitor
module tb_next_block_queue;
  logic pclk = 1'b0, rst, vblnk_in, take_req, take_ack;
  logic [4:0] random, cur_block, buf_block;
  logic [3:0] q_count;
  logic [4:0] exp_q[$];
  int n_checks = 0, n_fail = 0;

  next_block_queue #(.DEPTH(3), .MAX_RETRY(3)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .random    (random),
    .vblnk_in  (vblnk_in),
    .take_req  (take_req),
    .take_ack  (take_ack),
    .cur_block (cur_block),
    .buf_block (buf_block),
    .q_count   (q_count)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (take_ack === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: cur_block %b with no piece expected", cur_block);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (cur_block !== e) begin
          n_fail++;
          $display("FAIL ack_cur_block: got %b expected %b", cur_block, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; random = 5'd0; vblnk_in = 1'b0; take_req = 1'b0;
    repeat (2) step();
    chk("rst_count", 8'(q_count), 8'd0);
    chk("rst_ack", 8'(take_ack), 8'd0);
    chk("rst_cur", 8'(cur_block), 8'b00000);
    chk("rst_buf", 8'(buf_block), 8'b00000);
    rst = 1'b0;
    step(); chk("fill_r0", 8'(q_count), 8'd1);
    random = 5'd1; step(); chk("fill_r1", 8'(q_count), 8'd2);
    random = 5'd7; step(); chk("fill_r7", 8'(q_count), 8'd2);
    random = 5'd2; step(); chk("fill_r2", 8'(q_count), 8'd3);
    random = 5'd3; step(); chk("full_hold", 8'(q_count), 8'd3);
    random = 5'd7; take_req = 1'b1; exp_q.push_back(5'b10000);
    step();
    chk("hs_ack", 8'(take_ack), 8'd1);
    chk("hs_count", 8'(q_count), 8'd2);
    take_req = 1'b0;
    step(); chk("hs_no_second_ack", 8'(take_ack), 8'd0);
    random = 5'd3; step(); chk("refill", 8'(q_count), 8'd3);
    random = 5'd4; take_req = 1'b1; exp_q.push_back(5'b10001);
    step();
    chk("pp_ack", 8'(take_ack), 8'd1);
    chk("pp_count", 8'(q_count), 8'd3);
    take_req = 1'b0; random = 5'd7;
    step(); chk("pp_buf_unchanged", 8'(buf_block), 8'b00000);
    vblnk_in = 1'b1; step(); chk("pv_rise", 8'(buf_block), 8'b10010);
    take_req = 1'b1; exp_q.push_back(5'b10010);
    step(); chk("pv_pop_vblank_high", 8'(buf_block), 8'b10010);
    take_req = 1'b0;
    step(); chk("pv_hold", 8'(buf_block), 8'b10010);
    vblnk_in = 1'b0; step();
    vblnk_in = 1'b1; step(); chk("pv_rise2", 8'(buf_block), 8'b10011);
    vblnk_in = 1'b0; take_req = 1'b1; exp_q.push_back(5'b10011);
    step(); chk("pv_pop_vblank_low", 8'(buf_block), 8'b10011);
    take_req = 1'b0;
    step(); chk("pv_count", 8'(q_count), 8'd1);
    vblnk_in = 1'b1; step(); chk("pv_rise3", 8'(buf_block), 8'b10100);
    random = 5'd4; step();
`ifdef NBQ_NO_REPEAT_EN
    chk("nr_reject1", 8'(q_count), 8'd1);
    step(); step(); chk("nr_reject3", 8'(q_count), 8'd1);
    step(); chk("nr_forced", 8'(q_count), 8'd2);
`else
    chk("repeat_pushed", 8'(q_count), 8'd2);
`endif
    random = 5'd7; take_req = 1'b1; rst = 1'b1;
    step();
    chk("mid_rst_ack", 8'(take_ack), 8'd0);
    chk("mid_rst_count", 8'(q_count), 8'd0);
    chk("mid_rst_buf", 8'(buf_block), 8'b00000);
    step(); rst = 1'b0;
    repeat (20) step();
    chk("empty_no_ack", 8'(take_ack), 8'd0);
    chk("empty_count", 8'(q_count), 8'd0);
    random = 5'd5; exp_q.push_back(5'b10101);
    step(); chk("empty_push", 8'(q_count), 8'd1);
    random = 5'd7;
    step();
    chk("empty_ack", 8'(take_ack), 8'd1);
    chk("empty_count_after", 8'(q_count), 8'd0);
    take_req = 1'b0;
    step(); chk("empty_ack_done", 8'(take_ack), 8'd0);
    repeat (3) step();
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/next_block_queue.md
Name: next_block_queue

Overview:
Producer of the 5-bit tetromino codes consumed by the next-block preview draw stage (buf_block) and by game control (cur_block). Filters the free-running 5-bit random stream into legal codes 5'b10000..5'b10110 and keeps them in a small FIFO. Hands the head piece to game control over a req/ack handshake. Updates the preview code only at vertical-blank start, so the preview never changes mid-frame.

Parameters:
DEPTH, 3, queue entries (2..8); entry 0 is the head.
MAX_RETRY, 7, consecutive anti-repeat rejections before a repeat is forced (used only with NBQ_NO_REPEAT_EN).

Ports:
pclk  in  1  pixel clock.
rst  in  1  reset.
random  in  5  free-running random value; only bits [2:0] are used.
vblnk_in  in  1  vertical blank from the timing chain.
take_req  in  1  game control requests a new piece; held high until take_ack.
take_ack  out  1  one-cycle pulse: cur_block is updated this cycle.
cur_block  out  5  piece issued to game control; holds until the next ack.
buf_block  out  5  preview code for the next-block draw stage (head of queue, frame-synchronous).
q_count  out  4  current fill level, for debug.

Behaviour:
- Reset: rst, synchronous, active-high; clock pclk.
- Reset values: queue empty, q_count=0, take_ack=0, cur_block=5'b00000, buf_block=5'b00000, retry counter=0, vblnk_d=0.
- Reset mid-operation: a pending take_req is dropped with no ack; the queue refills from empty.
- Candidate each cycle:
  - cand = {2'b10, random[2:0]}.
  - Legal iff random[2:0] != 3'b111.
  - An illegal candidate is discarded; nothing is pushed that cycle.
- Push: a legal candidate is written to the tail when q_count < DEPTH, or when q_count == DEPTH and a pop happens in the same cycle. At most one push per cycle.
- FSM states:
  - FILL (q_count < DEPTH): push legal candidates.
  - FULL (q_count == DEPTH): no push unless a pop occurs that cycle.
  - Transitions follow q_count after each cycle's push/pop.
- Pop/handshake:
  - Accept when take_req=1, q_count>=1 and take_ack=0 in the current cycle.
  - On the next edge: cur_block <= q[0], entries shift down one, take_ack <= 1 for exactly one cycle.
  - After the ack, a still-high take_req is treated as a new request. The requester must drop it in the ack cycle to avoid a second piece.
  - q_count==0 with take_req high: wait, no ack. Accept once the first legal push has landed (pop happens one cycle after q_count becomes 1).
- Simultaneous push and pop: the shift and the tail write occur together. q_count is unchanged, and the new entry lands in slot q_count-1.
- Preview update:
  - vblnk_d is vblnk_in registered.
  - On the cycle where vblnk_in=1 and vblnk_d=0: buf_block <= q[0] if q_count>=1, else hold.
  - buf_block changes at no other time, even when a pop changes q[0]; the preview refreshes at the next vblank rise.
- No combinational path from any input to any output; every output is registered.

Optional Feature:
NBQ_NO_REPEAT_EN.
- Defined: a legal candidate equal to the last pushed code is rejected and the retry counter increments. When the counter reaches MAX_RETRY, the next legal candidate is accepted regardless and the counter clears. Any accepted push also clears it. The last-pushed register resets to 5'b00000.
- Undefined: no repeat check, no retry counter or last-pushed register; every legal candidate is pushable.

Decomposition:
- Shared package (tetris_pkg):
  - block code constants I_BLOCK..L_BLOCK (5'b10000..5'b10110) and NO_BLOCK=5'b00000.
  - BLOCK_W=5.
  - function is_legal_code.
  - The draw stages use the same constants.
- One sub-module, nbq_candidate_filter: registered last-pushed code and retry counter, producing cand and cand_ok. The queue/FSM/handshake stays in the top.

Test Plan:
- Fill after reset: rst for 2 cycles, random stepping 0,1,7,2 (DEPTH=3) -> q_count 0,1,2,2,3; queue = 10000,10001,10010; FULL holds with random=3.
- Handshake: queue full, random held at 7, take_req high -> take_ack one cycle later with cur_block=10000; q_count=2; requester drops take_req in the ack cycle -> no second ack.
- Push+pop same cycle: queue full, take_req high, random=4 -> cur_block=10000, queue = 10001,10010,10100, q_count stays 3.
- Empty wait: after reset, random held at 7 for 20 cycles with take_req high -> no ack; then random=5 -> q_count=1, ack next cycle with cur_block=10101.
- Preview sync: pop while vblnk_in=0 -> buf_block unchanged; vblnk_in 0->1 -> next cycle buf_block=new q[0]; vblnk held 1 -> no further change.
- NBQ_NO_REPEAT_EN, MAX_RETRY=3: last push 10010, random held at 2 -> three rejects, then 10010 pushed; without the macro it is pushed on the first cycle.
